// File: rtl/ball_mover.sv
// Ball position engine: samples tilt per axis on a divided update tick and
// walks the ball one pixel at a time, checking each target pixel against the
// maze map over a request/acknowledge port. X always resolves before Y.
module ball_mover #(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 5,
  parameter int CNTR_WIDTH             = 32,
  parameter int COORD_WIDTH            = 8,
  parameter int X_MAX                  = 127,
  parameter int Y_MAX                  = 127,
  parameter int X_START                = 0,
  parameter int Y_START                = 0,
  parameter int SPEED_WIDTH            = 2,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   x_increment,
  input  logic                   x_decrement,
  input  logic                   y_increment,
  input  logic                   y_decrement,
  input  logic [SPEED_WIDTH-1:0] x_speed,
  input  logic [SPEED_WIDTH-1:0] y_speed,
  output logic                   map_rd_req,
  output logic [COORD_WIDTH-1:0] map_addr_x,
  output logic [COORD_WIDTH-1:0] map_addr_y,
  input  logic                   map_rd_ack,
  input  logic                   map_blocked,
  output logic [COORD_WIDTH-1:0] x_out,
  output logic [COORD_WIDTH-1:0] y_out,
  output logic                   busy,
  output logic                   hit_wall,
  output logic                   tick_missed
);

  localparam logic [CNTR_WIDTH-1:0] TOP_CNT = (SIMULATE != 0) ?
    CNTR_WIDTH'(SIMULATE_FREQUENCY_CNT) :
    CNTR_WIDTH'(CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ - 1);
  localparam logic [COORD_WIDTH-1:0] X_MAX_C   = COORD_WIDTH'(X_MAX);
  localparam logic [COORD_WIDTH-1:0] Y_MAX_C   = COORD_WIDTH'(Y_MAX);
  localparam logic [COORD_WIDTH-1:0] X_START_C = COORD_WIDTH'(X_START);
  localparam logic [COORD_WIDTH-1:0] Y_START_C = COORD_WIDTH'(Y_START);
  localparam logic [SPEED_WIDTH-1:0] SPD_ONE   = SPEED_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_REQ_X, S_WAIT_X, S_REQ_Y, S_WAIT_Y} state_t;

  logic [CNTR_WIDTH-1:0]  r_cnt;
  logic                   r_tick;
  state_t                 r_state, w_state_nxt;
  logic [COORD_WIDTH-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [SPEED_WIDTH-1:0] r_xcnt, r_ycnt, w_xcnt_nxt, w_ycnt_nxt;
  logic                   r_xneg, r_yneg, w_xneg_nxt, w_yneg_nxt;
  logic                   r_req, w_req_nxt;
  logic [COORD_WIDTH-1:0] r_addr_x, r_addr_y, w_addr_x_nxt, w_addr_y_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_hit, w_hit_nxt;
  logic                   r_tmiss, w_tmiss_nxt;

  // Candidate pixels and edge-of-field checks, evaluated before any add so
  // the position can never wrap.
  logic [COORD_WIDTH-1:0] w_xcand, w_ycand;
  logic                   w_xoob, w_yoob;
  logic [SPEED_WIDTH-1:0] w_xcnt_dec, w_ycnt_dec;

  assign w_xcand    = r_xneg ? r_x - 1'b1 : r_x + 1'b1;
  assign w_ycand    = r_yneg ? r_y - 1'b1 : r_y + 1'b1;
  assign w_xoob     = r_xneg ? (r_x == '0) : (r_x >= X_MAX_C);
  assign w_yoob     = r_yneg ? (r_y == '0) : (r_y >= Y_MAX_C);
  assign w_xcnt_dec = r_xcnt - SPD_ONE;
  assign w_ycnt_dec = r_ycnt - SPD_ONE;

  // Update divider: one-cycle registered tick at terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == TOP_CNT) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  // FSM state and all registered outputs/datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= X_START_C;
      r_y      <= Y_START_C;
      r_xcnt   <= '0;
      r_ycnt   <= '0;
      r_xneg   <= 1'b0;
      r_yneg   <= 1'b0;
      r_req    <= 1'b0;
      r_addr_x <= '0;
      r_addr_y <= '0;
      r_busy   <= 1'b0;
      r_hit    <= 1'b0;
      r_tmiss  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_xcnt   <= w_xcnt_nxt;
      r_ycnt   <= w_ycnt_nxt;
      r_xneg   <= w_xneg_nxt;
      r_yneg   <= w_yneg_nxt;
      r_req    <= w_req_nxt;
      r_addr_x <= w_addr_x_nxt;
      r_addr_y <= w_addr_y_nxt;
      r_busy   <= w_busy_nxt;
      r_hit    <= w_hit_nxt;
      r_tmiss  <= w_tmiss_nxt;
    end
  end

  // Next-state and next-output decode; acks are only honoured in WAIT states.
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_xcnt_nxt   = r_xcnt;
    w_ycnt_nxt   = r_ycnt;
    w_xneg_nxt   = r_xneg;
    w_yneg_nxt   = r_yneg;
    w_req_nxt    = r_req;
    w_addr_x_nxt = r_addr_x;
    w_addr_y_nxt = r_addr_y;
    w_hit_nxt    = 1'b0;
    w_tmiss_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tick) begin
          w_xcnt_nxt = (x_increment ^ x_decrement) ? x_speed : '0;
          w_ycnt_nxt = (y_increment ^ y_decrement) ? y_speed : '0;
          w_xneg_nxt = x_decrement;
          w_yneg_nxt = y_decrement;
          if (w_xcnt_nxt != '0)      w_state_nxt = S_REQ_X;
          else if (w_ycnt_nxt != '0) w_state_nxt = S_REQ_Y;
        end
      end
      S_REQ_X: begin
        if (w_xoob) begin
          w_hit_nxt   = 1'b1;
          w_xcnt_nxt  = '0;
          w_state_nxt = (r_ycnt != '0) ? S_REQ_Y : S_IDLE;
        end else begin
          w_addr_x_nxt = w_xcand;
          w_addr_y_nxt = r_y;
          w_req_nxt    = 1'b1;
          w_state_nxt  = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        if (map_rd_ack) begin
          w_req_nxt = 1'b0;
          if (map_blocked) begin
            w_hit_nxt   = 1'b1;
            w_xcnt_nxt  = '0;
            w_state_nxt = (r_ycnt != '0) ? S_REQ_Y : S_IDLE;
          end else begin
            w_x_nxt     = r_addr_x;
            w_xcnt_nxt  = w_xcnt_dec;
            w_state_nxt = (w_xcnt_dec != '0) ? S_REQ_X :
                          (r_ycnt != '0)     ? S_REQ_Y : S_IDLE;
          end
        end
      end
      S_REQ_Y: begin
        if (w_yoob) begin
          w_hit_nxt   = 1'b1;
          w_ycnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_addr_x_nxt = r_x;
          w_addr_y_nxt = w_ycand;
          w_req_nxt    = 1'b1;
          w_state_nxt  = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        if (map_rd_ack) begin
          w_req_nxt = 1'b0;
          if (map_blocked) begin
            w_hit_nxt   = 1'b1;
            w_ycnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_y_nxt     = r_addr_y;
            w_ycnt_nxt  = w_ycnt_dec;
            w_state_nxt = (w_ycnt_dec != '0) ? S_REQ_Y : S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE && r_tick) w_tmiss_nxt = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign map_rd_req  = r_req;
  assign map_addr_x  = r_addr_x;
  assign map_addr_y  = r_addr_y;
  assign x_out       = r_x;
  assign y_out       = r_y;
  assign busy        = r_busy;
  assign hit_wall    = r_hit;
  assign tick_missed = r_tmiss;

endmodule

// File: tb/tb_ball_mover.sv
// Scoreboard bench for ball_mover: a pixel-walk reference model queues the
// expected map reads and end-of-update results; a negedge monitor pops them.
module tb_ball_mover;

  localparam int XMAX = 127;
  localparam int YMAX = 127;
  localparam int XS   = 10;
  localparam int YS   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_increment, x_decrement, y_increment, y_decrement;
  logic [1:0] x_speed, y_speed;
  logic       map_rd_req, map_rd_ack, map_blocked;
  logic [7:0] map_addr_x, map_addr_y, x_out, y_out;
  logic       busy, hit_wall, tick_missed;

  ball_mover #(
    .X_START(XS), .Y_START(YS), .X_MAX(XMAX), .Y_MAX(YMAX),
    .SIMULATE(1), .SIMULATE_FREQUENCY_CNT(5)
  ) dut (
    .clk(clk), .reset(reset),
    .x_increment(x_increment), .x_decrement(x_decrement),
    .y_increment(y_increment), .y_decrement(y_decrement),
    .x_speed(x_speed), .y_speed(y_speed),
    .map_rd_req(map_rd_req), .map_addr_x(map_addr_x), .map_addr_y(map_addr_y),
    .map_rd_ack(map_rd_ack), .map_blocked(map_blocked),
    .x_out(x_out), .y_out(y_out), .busy(busy),
    .hit_wall(hit_wall), .tick_missed(tick_missed)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; } req_t;
  typedef struct { int x; int y; int hits; } res_t;

  req_t req_q[$];
  res_t res_q[$];
  logic [127:0] wall [128];

  int checks = 0, errors = 0;
  int model_x = XS, model_y = YS;
  int lat = 0;
  int hits = 0, tm_cnt = 0, wcnt = 0;
  bit resp_en = 1, force_ack = 0, abort = 0;
  bit req_prev = 0, busy_prev = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Map responder: acks each request after lat extra cycles; map_blocked is
  // noise except in the ack cycle.
  always @(negedge clk) begin
    if (!resp_en) begin
      map_rd_ack  = force_ack;
      map_blocked = 1'b0;
      wcnt        = 0;
    end else if (map_rd_ack) begin
      map_rd_ack  = 1'b0;
      map_blocked = 1'($urandom);
    end else if (map_rd_req) begin
      if (wcnt >= lat) begin
        map_rd_ack  = 1'b1;
        map_blocked = wall[map_addr_x[6:0]][map_addr_y[6:0]];
        wcnt        = 0;
      end else begin
        wcnt++;
        map_blocked = 1'($urandom);
      end
    end else begin
      wcnt        = 0;
      map_blocked = 1'($urandom);
    end
  end

  // Monitor: checks every new request and every completed update.
  always @(negedge clk) begin
    if (busy && !busy_prev) hits = 0;
    if (hit_wall) hits++;
    if (tick_missed) tm_cnt++;
    if (map_rd_req && !req_prev) begin
      if (req_q.size() == 0) chk("unexpected_req", 1, 0);
      else begin
        req_t e;
        e = req_q.pop_front();
        chk("req_addr_x", int'(map_addr_x), e.x);
        chk("req_addr_y", int'(map_addr_y), e.y);
      end
    end
    if (!busy && busy_prev && !abort) begin
      if (res_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        res_t r;
        r = res_q.pop_front();
        chk("final_x", int'(x_out), r.x);
        chk("final_y", int'(y_out), r.y);
        chk("hit_count", hits, r.hits);
      end
    end
    req_prev  = map_rd_req;
    busy_prev = busy;
  end

  task automatic clear_walls();
    for (int i = 0; i < 128; i++) wall[i] = '0;
  endtask

  task automatic set_in(input bit xi, xd, yi, yd, input int xs, ys);
    x_increment = xi; x_decrement = xd;
    y_increment = yi; y_decrement = yd;
    x_speed = 2'(xs); y_speed = 2'(ys);
  endtask

  // Reference: walk pixel by pixel, X then Y, stopping at the field edge or
  // the first wall; queue expected reads and final result.
  task automatic run_txn(input bit xi, xd, yi, yd, input int xs, ys);
    int dx, dy, nx, ny, x, y, h, c, n;
    dx = (xi && !xd) ? 1 : (xd && !xi) ? -1 : 0;
    dy = (yi && !yd) ? 1 : (yd && !yi) ? -1 : 0;
    nx = (dx != 0) ? xs : 0;
    ny = (dy != 0) ? ys : 0;
    x = model_x; y = model_y; h = 0;
    for (int s = 0; s < nx; s++) begin
      c = x + dx;
      if (c < 0 || c > XMAX) begin h++; break; end
      req_q.push_back('{c, y});
      if (wall[c][y]) begin h++; break; end
      x = c;
    end
    for (int s = 0; s < ny; s++) begin
      c = y + dy;
      if (c < 0 || c > YMAX) begin h++; break; end
      req_q.push_back('{x, c});
      if (wall[x][c]) begin h++; break; end
      y = c;
    end
    model_x = x; model_y = y;
    @(negedge clk);
    set_in(xi, xd, yi, yd, xs, ys);
    if (nx != 0 || ny != 0) begin
      res_q.push_back('{x, y, h});
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      set_in(0, 0, 0, 0, 0, 0);
      if (!busy) chk("busy_rise_timeout", 0, 1);
      n = 0;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      if (busy) chk("busy_fall_timeout", 1, 0);
      @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
      chk("nomove_x", int'(x_out), model_x);
      chk("nomove_y", int'(y_out), model_y);
      chk("nomove_busy", int'(busy), 0);
    end
  endtask

  initial begin
    int tm0, n;
    clear_walls();
    set_in(0, 0, 0, 0, 0, 0);
    map_rd_ack = 1'b0; map_blocked = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(x_out), XS);
    chk("rst_y", int'(y_out), YS);
    chk("rst_req", int'(map_rd_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit_wall), 0);
    chk("rst_tmiss", int'(tick_missed), 0);
    reset = 1'b0;

    // Free move right by 3, then back.
    lat = 0;
    run_txn(1, 0, 0, 0, 3, 0);
    run_txn(0, 1, 0, 0, 3, 0);
    // Wall at (12,20) stops the walk at 11.
    wall[12][20] = 1'b1;
    run_txn(1, 0, 0, 0, 3, 0);
    chk("wall_stop_x", int'(x_out), 11);
    clear_walls();

    // Long ack latency: ticks during the wait are dropped.
    lat = 10;
    tm0 = tm_cnt;
    run_txn(0, 0, 1, 0, 0, 1);
    chk("tick_missed_seen", int'(tm_cnt > tm0), 1);

    // Randomized moves with scattered walls and latencies.
    for (int t = 0; t < 30; t++) begin
      clear_walls();
      for (int k = 0; k < 3; k++) begin
        int wx, wy;
        wx = model_x + int'($urandom_range(0, 8)) - 4;
        wy = model_y + int'($urandom_range(0, 8)) - 4;
        if (wx < 0) wx = 0;
        if (wx > 127) wx = 127;
        if (wy < 0) wy = 0;
        if (wy > 127) wy = 127;
        wall[wx][wy] = 1'b1;
      end
      lat = int'($urandom_range(0, 3));
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Walk to the origin, then probe the field edge.
    clear_walls();
    lat = 0;
    n = 0;
    while ((model_x > 0 || model_y > 0) && n < 60) begin
      run_txn(0, 1, 0, 1, 3, 3);
      n++;
    end
    chk("origin_x", int'(x_out), 0);
    chk("origin_y", int'(y_out), 0);
    run_txn(0, 1, 1, 0, 1, 1);
    chk("edge_x", int'(x_out), 0);
    chk("edge_y", int'(y_out), 1);
    run_txn(1, 1, 0, 0, 3, 0);

    // Reset while waiting on a Y read; a late ack must be ignored.
    resp_en = 0; abort = 1; lat = 0;
    req_q.push_back('{model_x, model_y - 1});
    @(negedge clk);
    set_in(0, 0, 0, 1, 0, 1);
    n = 0;
    while (!map_rd_req && n < 30) begin @(negedge clk); n++; end
    set_in(0, 0, 0, 0, 0, 0);
    chk("abort_req_seen", int'(map_rd_req), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_drop", int'(map_rd_req), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_x", int'(x_out), XS);
    chk("abort_y", int'(y_out), YS);
    chk("abort_busy", int'(busy), 0);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_x", int'(x_out), XS);
    chk("late_ack_y", int'(y_out), YS);
    chk("late_ack_busy", int'(busy), 0);
    chk("late_ack_req", int'(map_rd_req), 0);
    abort = 0; resp_en = 1;
    model_x = XS; model_y = YS;

    chk("req_q_empty", req_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ball_mover.md
# ball_mover

Parametrised ball-position engine for the labyrinth game. It samples tilt direction and speed per axis at a programmable update rate and advances the ball one pixel at a time, up to `speed` pixels per axis per update. Before each pixel it checks the target against the maze map through a request/acknowledge read port. It sits between the accelerometer decoder and the VGA sprite/overlay logic, and it replaces the fixed 4-bit, map-less position counter.

## Interface
- `CLK_FREQUENCY_HZ`, 100000000: system clock rate.
- `UPDATE_FREQUENCY_HZ`, 5: movement update rate.
- `CNTR_WIDTH`, 32: width of the update divider counter.
- `COORD_WIDTH`, 8: width of the X and Y coordinates.
- `X_MAX`, 127: largest legal X coordinate.
- `Y_MAX`, 127: largest legal Y coordinate.
- `X_START`, 0: X position at reset.
- `Y_START`, 0: Y position at reset.
- `SPEED_WIDTH`, 2: width of the per-axis speed inputs.
- `SIMULATE`, 0: when 1, the divider terminal count is `SIMULATE_FREQUENCY_CNT`.
- `SIMULATE_FREQUENCY_CNT`, 5: divider terminal count used in simulation.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `x_increment`, `x_decrement`, `y_increment`, `y_decrement`  in  1 each  tilt direction.
- `x_speed`, `y_speed`  in  SPEED_WIDTH each  pixels per update on each axis.
- `map_rd_req`  out  1  map read request.
- `map_addr_x`, `map_addr_y`  out  COORD_WIDTH each  candidate pixel to check.
- `map_rd_ack`  in  1  map read acknowledge.
- `map_blocked`  in  1  1 = the candidate pixel is a wall; valid only while `map_rd_ack` = 1.
- `x_out`, `y_out`  out  COORD_WIDTH each  current ball position.
- `busy`  out  1  high whenever the FSM is outside IDLE.
- `hit_wall`  out  1  one-cycle pulse when a step is refused.
- `tick_missed`  out  1  one-cycle pulse when an update tick arrives while busy.

## Operation
- **Update divider.** The divider counts 0..top_cnt. top_cnt = `SIMULATE` ? `SIMULATE_FREQUENCY_CNT` : `CLK_FREQUENCY_HZ`/`UPDATE_FREQUENCY_HZ` − 1. At terminal count the divider raises a registered `tick` for one cycle and wraps to 0.
- **FSM states:** IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y.
- **IDLE.** On `tick`, the block latches the direction and speed of both axes.
  - Direction per axis: inc-only = +1, dec-only = −1, both or neither = no move.
  - Remaining step counter per axis = latched speed, or 0 if there is no move.
  - Next state is REQ_X if the X count ≠ 0, else REQ_Y if the Y count ≠ 0, else stay in IDLE.
- **REQ_X.** The candidate is `x_out` ± 1.
  - If the candidate would be < 0 or > `X_MAX`, the step is refused with no map access: pulse `hit_wall`, clear the X count, go to Y handling.
  - Otherwise drive `map_addr_x` = candidate, `map_addr_y` = `y_out`, assert `map_rd_req`, and go to WAIT_X.
- **WAIT_X.** `map_rd_req` and the address stay stable until `map_rd_ack` = 1. In the ack cycle:
  - Blocked: `x_out` is unchanged, pulse `hit_wall`, clear the X count.
  - Free: `x_out` ← candidate and the X count decrements.
  - Next cycle `map_rd_req` = 0. If the X count is still ≠ 0 go to REQ_X, else go to REQ_Y (Y count ≠ 0) or IDLE.
- **REQ_Y / WAIT_Y.** Same as X, using `Y_MAX`, the new `x_out`, and the Y count. Finish in IDLE.
- **Ordering.** X always resolves before Y, so diagonal motion slides along walls.
- **Ticks while busy.** A `tick` arriving outside IDLE is dropped and pulses `tick_missed`. Latched inputs are not refreshed mid-update.
- **Arithmetic.** Unsigned COORD_WIDTH arithmetic. Boundary checks are made before the add, so positions never wrap.

## Timing
- **Reset values:** `x_out` = `X_START`, `y_out` = `Y_START`; `map_rd_req`, `busy`, `hit_wall`, `tick_missed` = 0; FSM = IDLE; divider = 0, `tick` = 0.
- **Reset mid-operation.** Reset aborts any access in progress. `map_rd_req` drops on the reset edge, and a late ack is ignored.
- **Output registration.** All outputs are registered.
- **Request timing.** `map_rd_req` rises one cycle after entering REQ.
- **Position update.** `x_out`/`y_out` update on the edge after the ack cycle.
- **Step cost.** Each checked step costs 2 + L cycles, where L = cycles from request to ack (L ≥ 1). A refused boundary step costs 1 cycle.
- **`busy`.** High from the cycle after `tick` until the cycle the FSM re-enters IDLE.
- **Ack outside WAIT.** An ack arriving in any state other than WAIT is ignored.

## Test plan
- **Reset values:** apply reset with `X_START` = 10, `Y_START` = 20 → `x_out` = 10, `y_out` = 20, `map_rd_req` = 0, `busy` = 0.
- **Free move:** all pixels free, ack latency 1, `x_increment` = 1, `x_speed` = 3 at (10,20) → three requests at x = 11, 12, 13; `x_out` = 13, `y_out` = 20; no `hit_wall`.
- **Wall stop:** wall at (12,20), `x_speed` = 3 from (10,20) → requests at 11 and 12 only; `x_out` = 11; one `hit_wall` pulse; FSM back in IDLE.
- **Boundary:** at (0,0) with `x_decrement` = 1 and `y_increment` = 1, speed 1 each → no X request, `hit_wall` pulses once, a Y request is made at (0,1), final position (0,1). Also: both X inc and dec asserted → X unchanged, no X request.
- **Tick while busy:** hold ack low for 10 cycles with `SIMULATE_FREQUENCY_CNT` = 5 → `tick_missed` pulses and only one update completes.
- **Reset mid-WAIT:** assert reset during WAIT_Y, then deliver ack → position returns to (`X_START`, `Y_START`); ack has no effect; `busy` = 0.
